// File: rtl/reorder_buffer.sv
// reorder_buffer
//   In-order retirement buffer for a dual-ALU out-of-order core. Dispatch
//   allocates one entry per cycle at the tail. Either ALU marks an entry done
//   through its writeback strobe. The head entry retires once it is done,
//   and its previous physical mapping is handed to the free pool.
//
// Ports
//   clk, rst                  single clock, asynchronous active-low reset
//   alloc_valid/_has_rd       dispatch request and "writes a destination" flag
//   alloc_areg/_preg/_old_preg architectural dest, new tag, tag being replaced
//   alloc_ready, rob_num      not-full indication, index handed to allocator
//   cmplN_valid, cmplN_rob    ALU0/ALU1 completion strobes and entry indices
//   flush                     synchronous discard of every entry
//   retire_valid/_areg/_preg  registered retirement report
//   rob_push, rob_free_reg    registered free-pool push
//   count, empty, full        occupancy status
module reorder_buffer #(
    parameter int PREG_WIDTH    = 6,
    parameter int AREG_WIDTH    = 5,
    parameter int ROB_DEPTH     = 16,
    parameter int ROB_IDX_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_valid,
    input  logic                    alloc_has_rd,
    input  logic [AREG_WIDTH-1:0]   alloc_areg,
    input  logic [PREG_WIDTH-1:0]   alloc_preg,
    input  logic [PREG_WIDTH-1:0]   alloc_old_preg,
    output logic                    alloc_ready,
    output logic [5:0]              rob_num,
    input  logic                    cmpl0_valid,
    input  logic                    cmpl1_valid,
    input  logic [5:0]              cmpl0_rob,
    input  logic [5:0]              cmpl1_rob,
    input  logic                    flush,
    output logic                    retire_valid,
    output logic [AREG_WIDTH-1:0]   retire_areg,
    output logic [PREG_WIDTH-1:0]   retire_preg,
    output logic                    rob_push,
    output logic [PREG_WIDTH-1:0]   rob_free_reg,
    output logic [ROB_IDX_WIDTH:0]  count,
    output logic                    empty,
    output logic                    full
);

    localparam int CW = ROB_IDX_WIDTH + 1;

    logic [ROB_DEPTH-1:0]     valid_q, valid_d;
    logic [ROB_DEPTH-1:0]     done_q, done_d;
    logic [ROB_DEPTH-1:0]     hasRd_q;
    logic [AREG_WIDTH-1:0]    areg_q    [ROB_DEPTH];
    logic [PREG_WIDTH-1:0]    preg_q    [ROB_DEPTH];
    logic [PREG_WIDTH-1:0]    oldPreg_q [ROB_DEPTH];

    logic [ROB_IDX_WIDTH-1:0] head_q, head_d;
    logic [ROB_IDX_WIDTH-1:0] tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;

    logic                     retValid_q, retValid_d;
    logic [AREG_WIDTH-1:0]    retAreg_q, retAreg_d;
    logic [PREG_WIDTH-1:0]    retPreg_q, retPreg_d;
    logic                     push_q, push_d;
    logic [PREG_WIDTH-1:0]    freeReg_q, freeReg_d;

    logic [ROB_IDX_WIDTH-1:0] cmpl0Idx, cmpl1Idx;
    logic                     allocFire, retireFire;
    logic                     unusedCmplBits;

    // Only the low index bits address an entry; the rest of the 6-bit tag is padding.
    assign cmpl0Idx       = cmpl0_rob[ROB_IDX_WIDTH-1:0];
    assign cmpl1Idx       = cmpl1_rob[ROB_IDX_WIDTH-1:0];
    assign unusedCmplBits = ^{cmpl0_rob[5:ROB_IDX_WIDTH], cmpl1_rob[5:ROB_IDX_WIDTH]};

    assign full        = (count_q == CW'(ROB_DEPTH));
    assign empty       = (count_q == '0);
    assign alloc_ready = !full;
    assign count       = count_q;
    assign rob_num     = 6'(tail_q);

    // Fullness is judged before the edge, so a retire cannot make room for
    // an allocation on the same edge.
    assign allocFire  = alloc_valid && !full;
    assign retireFire = valid_q[head_q] && done_q[head_q];

    // Next-state for the bookkeeping bits, pointers, count and retire report.
    // Completions are applied before retire and alloc so that a completion
    // landing on the retiring head is cleared along with it.
    always_comb begin
        valid_d    = valid_q;
        done_d     = done_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        retValid_d = 1'b0;
        retAreg_d  = '0;
        retPreg_d  = '0;
        push_d     = 1'b0;
        freeReg_d  = '0;

        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (cmpl0_valid && valid_q[cmpl0Idx]) begin
                done_d[cmpl0Idx] = 1'b1;
            end
            if (cmpl1_valid && valid_q[cmpl1Idx]) begin
                done_d[cmpl1Idx] = 1'b1;
            end
            if (retireFire) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + ROB_IDX_WIDTH'(1);
                retValid_d      = 1'b1;
                retAreg_d       = areg_q[head_q];
                retPreg_d       = preg_q[head_q];
                push_d          = hasRd_q[head_q];
                freeReg_d       = hasRd_q[head_q] ? oldPreg_q[head_q] : '0;
            end
            if (allocFire) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                tail_d          = tail_q + ROB_IDX_WIDTH'(1);
            end
            count_d = count_q + CW'(allocFire) - CW'(retireFire);
        end
    end

    // State register for everything that must be cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            done_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            retValid_q <= 1'b0;
            retAreg_q  <= '0;
            retPreg_q  <= '0;
            push_q     <= 1'b0;
            freeReg_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            done_q     <= done_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            retValid_q <= retValid_d;
            retAreg_q  <= retAreg_d;
            retPreg_q  <= retPreg_d;
            push_q     <= push_d;
            freeReg_q  <= freeReg_d;
        end
    end

    // Entry payload needs no reset: it is only read while the entry is valid.
    always_ff @(posedge clk) begin
        if (allocFire && !flush) begin
            hasRd_q[tail_q]   <= alloc_has_rd;
            areg_q[tail_q]    <= alloc_areg;
            preg_q[tail_q]    <= alloc_preg;
            oldPreg_q[tail_q] <= alloc_old_preg;
        end
    end

    assign retire_valid = retValid_q;
    assign retire_areg  = retAreg_q;
    assign retire_preg  = retPreg_q;
    assign rob_push     = push_q;
    assign rob_free_reg = freeReg_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer
//   Directed bench for reorder_buffer with a queue-based reference model and
//   a short randomised soak. The model holds the in-flight instructions in
//   program order and is compared against the DUT on every falling edge.
module tb_reorder_buffer;

    logic       clk;
    logic       rst;
    logic       alloc_valid;
    logic       alloc_has_rd;
    logic [4:0] alloc_areg;
    logic [5:0] alloc_preg;
    logic [5:0] alloc_old_preg;
    logic       alloc_ready;
    logic [5:0] rob_num;
    logic       cmpl0_valid;
    logic       cmpl1_valid;
    logic [5:0] cmpl0_rob;
    logic [5:0] cmpl1_rob;
    logic       flush;
    logic       retire_valid;
    logic [4:0] retire_areg;
    logic [5:0] retire_preg;
    logic       rob_push;
    logic [5:0] rob_free_reg;
    logic [4:0] count;
    logic       empty;
    logic       full;

    int testsRun = 0;
    int testsFailed = 0;

    reorder_buffer dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_has_rd   (alloc_has_rd),
        .alloc_areg     (alloc_areg),
        .alloc_preg     (alloc_preg),
        .alloc_old_preg (alloc_old_preg),
        .alloc_ready    (alloc_ready),
        .rob_num        (rob_num),
        .cmpl0_valid    (cmpl0_valid),
        .cmpl1_valid    (cmpl1_valid),
        .cmpl0_rob      (cmpl0_rob),
        .cmpl1_rob      (cmpl1_rob),
        .flush          (flush),
        .retire_valid   (retire_valid),
        .retire_areg    (retire_areg),
        .retire_preg    (retire_preg),
        .rob_push       (rob_push),
        .rob_free_reg   (rob_free_reg),
        .count          (count),
        .empty          (empty),
        .full           (full)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: in-flight instructions in program order.
    typedef struct packed {
        bit       done;
        bit       hasRd;
        bit [4:0] areg;
        bit [5:0] preg;
        bit [5:0] oldp;
        bit [3:0] idx;
    } entry_t;

    entry_t mq[$];
    entry_t mTmp;
    int     mTail = 0;
    int     mSize = 0;
    bit     mDoRet = 0;
    bit       expRetValid = 0;
    bit [4:0] expRetAreg = 0;
    bit [5:0] expRetPreg = 0;
    bit       expPush = 0;
    bit [5:0] expFree = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelClear();
        mq.delete();
        mTail       = 0;
        expRetValid = 0;
        expRetAreg  = 0;
        expRetPreg  = 0;
        expPush     = 0;
        expFree     = 0;
    endtask

    // Asynchronous reset empties the model immediately.
    always @(negedge rst) modelClear();

    // Model step on each rising edge using the inputs held across it.
    always @(posedge clk) begin
        if (rst) begin
            if (flush) begin
                modelClear();
            end else begin
                mSize  = mq.size();
                mDoRet = (mSize > 0) && mq[0].done;
                for (int k = 0; k < mSize; k++) begin
                    if ((cmpl0_valid && mq[k].idx == cmpl0_rob[3:0]) ||
                        (cmpl1_valid && mq[k].idx == cmpl1_rob[3:0])) begin
                        mTmp      = mq[k];
                        mTmp.done = 1'b1;
                        mq[k]     = mTmp;
                    end
                end
                if (alloc_valid && mSize < 16) begin
                    mTmp.done  = 1'b0;
                    mTmp.hasRd = alloc_has_rd;
                    mTmp.areg  = alloc_areg;
                    mTmp.preg  = alloc_preg;
                    mTmp.oldp  = alloc_old_preg;
                    mTmp.idx   = 4'(mTail);
                    mq.push_back(mTmp);
                    mTail = (mTail + 1) % 16;
                end
                if (mDoRet) begin
                    mTmp        = mq.pop_front();
                    expRetValid = 1'b1;
                    expRetAreg  = mTmp.areg;
                    expRetPreg  = mTmp.preg;
                    expPush     = mTmp.hasRd;
                    expFree     = mTmp.hasRd ? mTmp.oldp : 6'd0;
                end else begin
                    expRetValid = 1'b0;
                    expRetAreg  = 0;
                    expRetPreg  = 0;
                    expPush     = 1'b0;
                    expFree     = 0;
                end
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        checkOutput("m_count",     count,        mq.size());
        checkOutput("m_empty",     empty,        mq.size() == 0);
        checkOutput("m_full",      full,         mq.size() == 16);
        checkOutput("m_ready",     alloc_ready,  mq.size() != 16);
        checkOutput("m_rob_num",   rob_num,      mTail);
        checkOutput("m_ret_valid", retire_valid, expRetValid);
        checkOutput("m_ret_areg",  retire_areg,  expRetAreg);
        checkOutput("m_ret_preg",  retire_preg,  expRetPreg);
        checkOutput("m_push",      rob_push,     expPush);
        checkOutput("m_free_reg",  rob_free_reg, expFree);
    end

    // Drive one edge's worth of inputs, then return just after that edge.
    task automatic applyStimulus(input bit av, input bit hasRd, input int areg, input int preg,
                                 input int oldp, input bit c0v, input int c0r, input bit c1v,
                                 input int c1r, input bit fl);
        @(negedge clk);
        #1;
        alloc_valid    = av;
        alloc_has_rd   = hasRd;
        alloc_areg     = 5'(areg);
        alloc_preg     = 6'(preg);
        alloc_old_preg = 6'(oldp);
        cmpl0_valid    = c0v;
        cmpl0_rob      = 6'(c0r);
        cmpl1_valid    = c1v;
        cmpl1_rob      = 6'(c1r);
        flush          = fl;
        @(posedge clk);
        #1;
        alloc_valid    = 1'b0;
        alloc_has_rd   = 1'b0;
        alloc_areg     = '0;
        alloc_preg     = '0;
        alloc_old_preg = '0;
        cmpl0_valid    = 1'b0;
        cmpl0_rob      = '0;
        cmpl1_valid    = 1'b0;
        cmpl1_rob      = '0;
        flush          = 1'b0;
    endtask

    task automatic alloc(input bit hasRd, input int areg, input int preg, input int oldp);
        applyStimulus(1, hasRd, areg, preg, oldp, 0, 0, 0, 0, 0);
    endtask

    task automatic complete(input int idx);
        applyStimulus(0, 0, 0, 0, 0, 1, idx, 0, 0, 0);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Directed scenarios followed by a random soak.
    initial begin
        rst            = 1'b1;
        alloc_valid    = 1'b0;
        alloc_has_rd   = 1'b0;
        alloc_areg     = '0;
        alloc_preg     = '0;
        alloc_old_preg = '0;
        cmpl0_valid    = 1'b0;
        cmpl0_rob      = '0;
        cmpl1_valid    = 1'b0;
        cmpl1_rob      = '0;
        flush          = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full",  full, 0);
        checkOutput("rst_ready", alloc_ready, 1);
        checkOutput("rst_rob_num", rob_num, 0);
        checkOutput("rst_ret_valid", retire_valid, 0);
        #2 rst = 1'b1;

        // Three allocations receive consecutive indices.
        alloc(1, 1, 33, 1);
        checkOutput("a1_rob_num", rob_num, 1);
        alloc(1, 2, 34, 2);
        checkOutput("a2_rob_num", rob_num, 2);
        alloc(1, 3, 35, 3);
        checkOutput("a3_rob_num", rob_num, 3);
        checkOutput("a3_count", count, 3);
        checkOutput("a3_ret_valid", retire_valid, 0);

        // Out-of-order completion, in-order retirement.
        complete(1);
        checkOutput("c1_ret_valid", retire_valid, 0);
        complete(0);
        checkOutput("c0_ret_valid", retire_valid, 0);
        idle();
        checkOutput("r0_ret_valid", retire_valid, 1);
        checkOutput("r0_ret_areg", retire_areg, 1);
        checkOutput("r0_ret_preg", retire_preg, 33);
        checkOutput("r0_free_reg", rob_free_reg, 1);
        checkOutput("r0_push", rob_push, 1);
        idle();
        checkOutput("r1_ret_valid", retire_valid, 1);
        checkOutput("r1_free_reg", rob_free_reg, 2);
        checkOutput("r1_push", rob_push, 1);
        checkOutput("r1_count", count, 1);
        idle();
        checkOutput("r2_ret_valid", retire_valid, 0);
        checkOutput("r2_count", count, 1);

        // Fill from index 0, overflow attempt, blocked alloc on retire edge, wrap.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("fl_count", count, 0);
        for (int i = 0; i < 16; i++) alloc(1, i, i + 16, i);
        checkOutput("fill_full", full, 1);
        checkOutput("fill_ready", alloc_ready, 0);
        checkOutput("fill_count", count, 16);
        checkOutput("fill_rob_num", rob_num, 0);
        alloc(1, 20, 50, 20);
        checkOutput("ovf_count", count, 16);
        applyStimulus(1, 1, 20, 50, 20, 1, 0, 0, 0, 0);
        checkOutput("hold_count", count, 16);
        checkOutput("hold_ret_valid", retire_valid, 0);
        alloc(1, 21, 51, 21);
        checkOutput("blk_count", count, 15);
        checkOutput("blk_ret_valid", retire_valid, 1);
        checkOutput("blk_rob_num", rob_num, 0);
        alloc(1, 22, 52, 22);
        checkOutput("wrap_count", count, 16);
        checkOutput("wrap_rob_num", rob_num, 1);

        // Both ports completing the head on the same edge.
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
        idle();
        checkOutput("dual_ret_valid", retire_valid, 1);
        checkOutput("dual_ret_areg", retire_areg, 1);
        checkOutput("dual_count", count, 15);
        idle();
        checkOutput("dual2_ret_valid", retire_valid, 0);
        checkOutput("dual2_count", count, 15);

        // Completion to an empty slot is ignored.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        complete(9);
        checkOutput("cinv_count", count, 0);
        checkOutput("cinv_empty", empty, 1);
        idle();
        checkOutput("cinv_ret_valid", retire_valid, 0);

        // Entry without a destination retires without a free-pool push.
        alloc(0, 7, 40, 12);
        complete(0);
        idle();
        checkOutput("nord_ret_valid", retire_valid, 1);
        checkOutput("nord_ret_areg", retire_areg, 7);
        checkOutput("nord_ret_preg", retire_preg, 40);
        checkOutput("nord_push", rob_push, 0);
        checkOutput("nord_free_reg", rob_free_reg, 0);

        // Flush beats alloc, completion and a ready retire.
        for (int i = 1; i <= 5; i++) alloc(1, 10 + i, 20 + i, i + 1);
        checkOutput("pre_fl_count", count, 5);
        complete(1);
        applyStimulus(1, 1, 30, 60, 30, 1, 1, 0, 0, 1);
        checkOutput("fl2_count", count, 0);
        checkOutput("fl2_empty", empty, 1);
        checkOutput("fl2_rob_num", rob_num, 0);
        checkOutput("fl2_ret_valid", retire_valid, 0);
        idle();
        checkOutput("fl3_ret_valid", retire_valid, 0);

        // Asynchronous reset in the middle of a cycle.
        alloc(1, 4, 44, 14);
        alloc(1, 5, 45, 15);
        complete(0);
        idle();
        checkOutput("pre_rst_ret_valid", retire_valid, 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("arst_count", count, 0);
        checkOutput("arst_empty", empty, 1);
        checkOutput("arst_rob_num", rob_num, 0);
        checkOutput("arst_ret_valid", retire_valid, 0);
        checkOutput("arst_push", rob_push, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        alloc(1, 6, 46, 16);
        checkOutput("post_rst_count", count, 1);
        checkOutput("post_rst_rob_num", rob_num, 1);

        // Random soak checked by the model.
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                          int'($urandom_range(0, 63)),
                          1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                          1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                          $urandom_range(0, 40) == 0);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
